// File: rtl/saxi_write_resp_merger_3to1.sv
// Merges three per-SLR AXI4-Lite B channels into one; the merged BRESP is the most severe.
// Optional SAXI_BMERGE_ERR_COUNT_EN adds a saturating count of merged SLVERR/DECERR responses.
module saxi_write_resp_merger_3to1 #(
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic       ap_clk,
    input  logic       ap_rst,
    input  logic       s_axi_control_BVALID_slr_0,
    output logic       s_axi_control_BREADY_slr_0,
    input  logic [1:0] s_axi_control_BRESP_slr_0,
    input  logic       s_axi_control_BVALID_slr_1,
    output logic       s_axi_control_BREADY_slr_1,
    input  logic [1:0] s_axi_control_BRESP_slr_1,
    input  logic       s_axi_control_BVALID_slr_2,
    output logic       s_axi_control_BREADY_slr_2,
    input  logic [1:0] s_axi_control_BRESP_slr_2,
    output logic       s_axi_control_BVALID,
    input  logic       s_axi_control_BREADY,
    output logic [1:0] s_axi_control_BRESP
`ifdef SAXI_BMERGE_ERR_COUNT_EN
    ,
    output logic [15:0] resp_err_count
`endif
);

    localparam logic [FIFO_ADDR_WIDTH:0] CNT_FULL = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);

    logic [2:0]                 in_valid;
    logic [2:0]                 in_ready;
    logic [2:0]                 push;
    logic [1:0]                 in_resp [3];
    logic [1:0]                 head    [3];
    logic [1:0]                 mem     [3][FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wptr    [3];
    logic [FIFO_ADDR_WIDTH-1:0] rptr    [3];
    logic [FIFO_ADDR_WIDTH:0]   cnt     [3];
    logic                       all_avail;
    logic                       pop;
    logic [1:0]                 max01;
    logic [1:0]                 merged;

    assign in_valid   = {s_axi_control_BVALID_slr_2, s_axi_control_BVALID_slr_1,
                         s_axi_control_BVALID_slr_0};
    assign in_resp[0] = s_axi_control_BRESP_slr_0;
    assign in_resp[1] = s_axi_control_BRESP_slr_1;
    assign in_resp[2] = s_axi_control_BRESP_slr_2;

    assign s_axi_control_BREADY_slr_0 = in_ready[0];
    assign s_axi_control_BREADY_slr_1 = in_ready[1];
    assign s_axi_control_BREADY_slr_2 = in_ready[2];

    // Ready looks only at occupancy: a full FIFO refuses even when it is popped this cycle.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            in_ready[k] = (cnt[k] != CNT_FULL);
            push[k]     = in_valid[k] & in_ready[k];
            head[k]     = mem[k][rptr[k]];
        end
    end

    assign all_avail = (cnt[0] != '0) & (cnt[1] != '0) & (cnt[2] != '0);
    assign pop       = all_avail & (~s_axi_control_BVALID | s_axi_control_BREADY);
    assign max01     = (head[0] > head[1]) ? head[0] : head[1];
    assign merged    = (max01 > head[2]) ? max01 : head[2];

    always_ff @(posedge ap_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (push[k]) begin
                mem[k][wptr[k]] <= in_resp[k];
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int k = 0; k < 3; k++) begin
                wptr[k] <= '0;
                rptr[k] <= '0;
                cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (push[k]) begin
                    wptr[k] <= wptr[k] + FIFO_ADDR_WIDTH'(1);
                end
                if (pop) begin
                    rptr[k] <= rptr[k] + FIFO_ADDR_WIDTH'(1);
                end
                case ({push[k], pop})
                    2'b10:   cnt[k] <= cnt[k] + (FIFO_ADDR_WIDTH+1)'(1);
                    2'b01:   cnt[k] <= cnt[k] - (FIFO_ADDR_WIDTH+1)'(1);
                    default: cnt[k] <= cnt[k];
                endcase
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s_axi_control_BVALID <= 1'b0;
            s_axi_control_BRESP  <= 2'b00;
        end else if (pop) begin
            s_axi_control_BVALID <= 1'b1;
            s_axi_control_BRESP  <= merged;
        end else if (s_axi_control_BREADY) begin
            s_axi_control_BVALID <= 1'b0;
        end
    end

`ifdef SAXI_BMERGE_ERR_COUNT_EN
    logic [15:0] err_cnt;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            err_cnt <= 16'h0000;
        end else if (pop && merged[1] && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign resp_err_count = err_cnt;
`endif

endmodule
